i2s_transmitter: RTL and testbench

I2S_TRANSMITTER -- requirements
Module: i2s_transmitter

---
 rtl/fpgc_audio_pkg.sv | 44 ++++
 rtl/sample_fifo.sv | 84 ++++++++
 rtl/i2s_transmitter.sv | 132 +++++++++++++
 tb/tb_i2s_transmitter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fpgc_audio_pkg.sv
// rtl/fpgc_audio_pkg.sv - I2S frame constants and slot-to-bit mapping shared by the audio path
package fpgc_audio_pkg;

    // Frame counter geometry: one frame is 1024 system clocks.
    localparam int FCNT_BITS         = 10;

    // Divider taps on the frame counter.
    localparam int MCLK_BIT          = 1;
    localparam int SCLK_BIT          = 3;
    localparam int LRCLK_BIT         = 9;

    // A bit slot lasts one SCLK period, so the slot index starts just above the SCLK tap.
    localparam int SLOT_LSB          = SCLK_BIT + 1;
    localparam int SLOT_BITS         = FCNT_BITS - SLOT_LSB;

    localparam int SAMPLE_BITS       = 16;
    localparam int SLOTS_PER_CHANNEL = 32;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } i2s_chan_e;

    typedef logic [2*SAMPLE_BITS-1:0] sample_word_t;

    // Serial bit for a given slot of the frame. The data is delayed by one slot
    // behind the LRCLK edge, so within each 32-slot channel half, slots 1..16
    // carry the sample MSB first and every other slot is zero.
    function automatic logic slot_bit(input sample_word_t word, input logic [SLOT_BITS-1:0] slot);
        i2s_chan_e              chan;
        logic [4:0]             ch_slot;
        logic [3:0]             idx;
        logic [SAMPLE_BITS-1:0] chan_data;
        chan      = i2s_chan_e'(slot[SLOT_BITS-1]);
        ch_slot   = slot[4:0];
        chan_data = (chan == CH_LEFT) ? word[2*SAMPLE_BITS-1:SAMPLE_BITS] : word[SAMPLE_BITS-1:0];
        idx       = ch_slot[3:0] - 4'd1;
        if ((ch_slot != 5'd0) && (ch_slot <= 5'(SAMPLE_BITS))) begin
            return chan_data[4'd15 - idx];
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - single-clock sample FIFO with registered head word and registered status
module sample_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = 1;
    localparam logic [AW:0]   LEVEL_ONE = 1;
    localparam logic [AW:0]   LEVEL_MAX = DEPTH;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             push;
    logic             pop;

    // Accept a pop only when data exists; a write into a full FIFO survives only alongside a pop.
    always_comb begin
        pop      = rd_en && !empty_q;
        push     = wr_en && (!full_q || pop);
        wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + LEVEL_ONE;
        end else if (pop && !push) begin
            level_d = level_q - LEVEL_ONE;
        end
        full_d  = (level_d == LEVEL_MAX);
        empty_d = (level_d == '0);
        // The next head is the slot at the new read pointer, bypassed when that slot is written now.
        head_d  = mem_q[rd_ptr_d];
        if (push && (wr_ptr_q == rd_ptr_d)) begin
            head_d = wr_data;
        end
    end

    // Pointer, level, status and head registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            head_q   <= head_d;
        end
    end

    // Storage array; contents are don't-care after reset since the pointers are cleared.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = head_q;
    assign full    = full_q;
    assign empty   = empty_q;
    assign level   = level_q;

endmodule

// File: rtl/i2s_transmitter.sv
// rtl/i2s_transmitter.sv - I2S audio transmitter; define I2S_UNDERRUN_IRQ_EN to build the underrun pulse
module i2s_transmitter
    import fpgc_audio_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [31:0]                   sample_data,
    input  logic                          sample_we,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun_int,
    output logic                          I2S_MCLK,
    output logic                          I2S_SCLK,
    output logic                          I2S_LRCLK,
    output logic                          I2S_SDIN,
    output logic                          active
);

    localparam logic [FCNT_BITS-1:0] FCNT_ONE  = 1;
    localparam logic [FCNT_BITS-1:0] FCNT_LAST = '1;

    logic [FCNT_BITS-1:0] fcnt_q, fcnt_d;
    logic                 mclk_q, mclk_d;
    logic                 sclk_q, sclk_d;
    logic                 lrclk_q, lrclk_d;
    logic                 sdin_q, sdin_d;
    logic                 active_q, active_d;
    sample_word_t         frame_q, frame_d;
    sample_word_t         fifo_head;
    logic                 frame_end;
    logic                 pop;

    // The last clock of a running frame is where the next sample is fetched.
    assign frame_end = enable && (fcnt_q == FCNT_LAST);
    assign pop       = frame_end && !fifo_empty;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2*SAMPLE_BITS)
    ) u_sample_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (sample_we),
        .wr_data (sample_data),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Frame counter, clock taps, frame word and serial bit for the next cycle.
    always_comb begin
        fcnt_d   = enable ? (fcnt_q + FCNT_ONE) : '0;
        // Clocks are registered copies of the next counter value, so they track fcnt_q exactly.
        mclk_d   = fcnt_d[MCLK_BIT];
        sclk_d   = fcnt_d[SCLK_BIT];
        lrclk_d  = fcnt_d[LRCLK_BIT];
        frame_d  = frame_q;
        active_d = active_q;
        if (!enable) begin
            // Stopping aborts the frame; the held word is discarded.
            frame_d  = '0;
            active_d = 1'b0;
        end else if (frame_end) begin
            // An empty FIFO leaves a zero frame with the activity flag low.
            frame_d  = pop ? fifo_head : '0;
            active_d = pop;
        end
        sdin_d = sdin_q;
        if (!enable) begin
            sdin_d = 1'b0;
        end else if (fcnt_d[SCLK_BIT:0] == '0) begin
            // Data changes only as SCLK falls, i.e. at the start of each slot.
            sdin_d = slot_bit(frame_d, fcnt_d[FCNT_BITS-1:SLOT_LSB]);
        end
    end

    // Frame state and output pin registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fcnt_q   <= '0;
            mclk_q   <= 1'b0;
            sclk_q   <= 1'b0;
            lrclk_q  <= 1'b0;
            sdin_q   <= 1'b0;
            active_q <= 1'b0;
            frame_q  <= '0;
        end else begin
            fcnt_q   <= fcnt_d;
            mclk_q   <= mclk_d;
            sclk_q   <= sclk_d;
            lrclk_q  <= lrclk_d;
            sdin_q   <= sdin_d;
            active_q <= active_d;
            frame_q  <= frame_d;
        end
    end

`ifdef I2S_UNDERRUN_IRQ_EN
    logic underrun_q, underrun_d;

    // Flag a frame boundary that found nothing to send; frame_end lasts one clock so this is a pulse.
    always_comb begin
        underrun_d = frame_end && fifo_empty;
    end

    // Underrun pulse register.
    always_ff @(posedge clk) begin
        if (reset) begin
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= underrun_d;
        end
    end

    assign underrun_int = underrun_q;
`else
    assign underrun_int = 1'b0;
`endif

    assign I2S_MCLK  = mclk_q;
    assign I2S_SCLK  = sclk_q;
    assign I2S_LRCLK = lrclk_q;
    assign I2S_SDIN  = sdin_q;
    assign active    = active_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// tb/tb_i2s_transmitter.sv - self-checking bench for i2s_transmitter against a queue-based frame model
module tb_i2s_transmitter;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] sample_data = '0;
    logic        sample_we = 1'b0;
    logic        fifo_full;
    logic        fifo_empty;
    logic [4:0]  fifo_level;
    logic        underrun_int;
    logic        I2S_MCLK;
    logic        I2S_SCLK;
    logic        I2S_LRCLK;
    logic        I2S_SDIN;
    logic        active;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state: queued words, frame position, word being sent.
    logic [31:0] mq[$];
    int          m_fcnt = 0;
    logic [31:0] m_cur = '0;
    bit          m_act = 1'b0;

    bit prev_run  = 1'b0;
    bit prev_sdin = 1'b0;
    bit prev_sclk = 1'b0;

    typedef struct {
        bit          r;
        bit          e;
        bit          w;
        logic [31:0] d;
        int          lvl;
        bit          full;
        bit          empty;
    } vec_t;

    vec_t        tbl[20];
    logic [63:0] cap;
    bit          en_r;
    bit          rst_r;
    bit          we_r;

    i2s_transmitter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sample_data  (sample_data),
        .sample_we    (sample_we),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .fifo_level   (fifo_level),
        .underrun_int (underrun_int),
        .I2S_MCLK     (I2S_MCLK),
        .I2S_SCLK     (I2S_SCLK),
        .I2S_LRCLK    (I2S_LRCLK),
        .I2S_SDIN     (I2S_SDIN),
        .active       (active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (model fcnt %0d, t=%0t)", name, act, exp, m_fcnt, $time);
        end
    endtask

    // Slot s of a frame: left bits in slots 1..16, right bits in slots 33..48, MSB first.
    function automatic bit exp_bit(input logic [31:0] w, input int s);
        if (s >= 1 && s <= 16) return w[32 - s];
        if (s >= 33 && s <= 48) return w[48 - s];
        return 1'b0;
    endfunction

    task automatic step(input bit r, input bit e, input bit w, input logic [31:0] d);
        bit         at_end;
        bit         pop;
        bit         und;
        logic [5:0] exp_pins;
        reset       = r;
        enable      = e;
        sample_we   = w;
        sample_data = d;
        @(posedge clk);
        #1;
        und = 1'b0;
        if (r) begin
            mq.delete();
            m_fcnt = 0;
            m_cur  = '0;
            m_act  = 1'b0;
        end else begin
            at_end = e && (m_fcnt == 1023);
            pop    = at_end && (mq.size() > 0);
            und    = at_end && (mq.size() == 0);
            if (!e) begin
                m_cur = '0;
                m_act = 1'b0;
            end else if (at_end) begin
                if (pop) begin
                    m_cur = mq.pop_front();
                    m_act = 1'b1;
                end else begin
                    m_cur = '0;
                    m_act = 1'b0;
                end
            end
            if (w && mq.size() < DEPTH) mq.push_back(d);
            m_fcnt = e ? (m_fcnt + 1) % 1024 : 0;
        end
`ifndef I2S_UNDERRUN_IRQ_EN
        und = 1'b0;
`endif
        exp_pins = {und, m_act, exp_bit(m_cur, m_fcnt / 16),
                    1'(m_fcnt / 512), 1'((m_fcnt >> 3) & 1), 1'((m_fcnt >> 1) & 1)};
        chk("fifo_status", {fifo_level, fifo_full, fifo_empty},
            {5'(mq.size()), (mq.size() == DEPTH), (mq.size() == 0)});
        chk("i2s_pins", {underrun_int, active, I2S_SDIN, I2S_LRCLK, I2S_SCLK, I2S_MCLK}, exp_pins);
        if (prev_run && e && !r && (I2S_SDIN !== prev_sdin)) begin
            chk("sdin_on_sclk_fall", {prev_sclk, I2S_SCLK}, 2'b10);
        end
        prev_run  = e && !r;
        prev_sdin = I2S_SDIN;
        prev_sclk = I2S_SCLK;
    endtask

    initial begin
        // FIFO fill with audio stopped: reset, reset overriding a write, 17 writes, idle.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0, 0, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 1'b1};
        for (int i = 0; i < 17; i++) begin
            tbl[i + 2] = '{1'b0, 1'b0, 1'b1, 32'h8001_4002 + 32'(i) * 32'h0101_0101,
                           (i < 16) ? i + 1 : 16, (i >= 15), 1'b0};
        end
        tbl[19] = '{1'b0, 1'b0, 1'b0, 32'h0, 16, 1'b1, 1'b0};

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].r, tbl[i].e, tbl[i].w, tbl[i].d);
            chk("tbl_level", fifo_level, tbl[i].lvl);
            chk("tbl_full_empty", {fifo_full, fifo_empty}, {tbl[i].full, tbl[i].empty});
            chk("tbl_pins_idle", {underrun_int, active, I2S_SDIN, I2S_LRCLK, I2S_SCLK, I2S_MCLK}, 6'b0);
        end

        // Read back the 16 stored words over the following frames; the 17th write must not appear.
        for (int i = 0; i < 17 * 1024 + 10; i++) step(1'b0, 1'b1, 1'b0, 32'h0);

        // Single word A5A5_3C3C: frame 1 silent, frame 2 carries it.
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'hA5A5_3C3C);
        cap = '0;
        for (int i = 1; i <= 2048; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            if (i == 1000) chk("frame1_active", active, 1'b0);
            if (i == 1024) chk("frame2_active", active, 1'b1);
            if (i >= 1024 && (i % 16) == 8) cap = {cap[62:0], I2S_SDIN};
            if (i == 2048) begin
`ifdef I2S_UNDERRUN_IRQ_EN
                chk("underrun_after_word", underrun_int, 1'b1);
`else
                chk("underrun_after_word", underrun_int, 1'b0);
`endif
            end
        end
        chk("frame2_slots", cap, {1'b0, 16'hA5A5, 16'h0000, 16'h3C3C, 15'h0});

        // Reset mid-frame at fcnt=500 with five words queued.
        step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 32'h1234_0000 + 32'(i));
        for (int i = 0; i < 500; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        chk("rst_level", {fifo_level, fifo_full, fifo_empty}, {5'd0, 1'b0, 1'b1});
        chk("rst_pins", {underrun_int, active, I2S_SDIN, I2S_LRCLK, I2S_SCLK, I2S_MCLK}, 6'b0);
        for (int k = 1; k <= 1023; k++) step(1'b0, 1'b1, (k == 1), 32'h7FFF_8001);
        chk("pre_pop_active", {active, fifo_level}, {1'b0, 5'd1});
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("first_pop_after_reset", {active, fifo_level}, {1'b1, 5'd0});

        // Full FIFO with a write at fcnt=1023: pop and write both land.
        step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b1, 32'hC000_0000 + 32'(i));
        for (int k = 1; k <= 1023; k++) step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h5A5A_F00F);
        chk("full_pop_write_level", {fifo_level, fifo_full}, {5'd16, 1'b1});
        step(1'b0, 1'b1, 1'b1, 32'h0BAD_0BAD);
        chk("full_write_dropped", {fifo_level, fifo_full}, {5'd16, 1'b1});

        // Randomized traffic, enable toggles and occasional reset against the model.
        en_r = 1'b1;
        for (int i = 0; i < 30000; i++) begin
            rst_r = ($urandom_range(0, 9999) == 0);
            we_r  = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 3999) == 0) en_r = !en_r;
            step(rst_r, en_r, we_r, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
